// File: rtl/display_pkg.sv
// Shared display types and helpers for the seven-segment display path.
package display_pkg;

  localparam int DIGITS_DEFAULT = 4;

  // One hex/BCD digit code as presented to the segment decoder.
  typedef logic [3:0] digit_t;

  // Width of a digit index for n digits; never less than 1 bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks.
module tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV <= 2) ? 1 : $clog2(DIV);

  logic [CW-1:0] div_cnt;

  assign tick = (div_cnt == CW'(DIV - 1));

  // Count up every cycle, wrapping to 0 on the tick cycle.
  always_ff @(posedge clk) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

endmodule

// File: rtl/digit_scanner.sv
// Time-multiplexed digit scanner with frame-aligned double buffering
// and leading-zero blanking; feeds seven_segment.num.
module digit_scanner
  import display_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEFAULT,
  parameter int DIV    = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic                  load_i,
  input  logic                  blank_lz_i,
  output digit_t                num_o,
  output logic [DIGITS-1:0]     digit_en_o,
  output logic                  blank_o,
  output logic                  pending_o
);

  localparam int IW = idx_w(DIGITS);

  logic                     tick;
  logic                     wrap;
  logic [IW-1:0]            idx;
  digit_t [DIGITS-1:0]      shadow;
  digit_t [DIGITS-1:0]      active;
  logic                     pending;
  // zero_from[k]: digits k..DIGITS-1 of the active value are all zero
  logic [DIGITS-1:0]        zero_from;

  tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign wrap = tick && (idx == IW'(DIGITS - 1));

  // Digit index: advance on each tick, wrap after the last digit.
  always_ff @(posedge clk) begin
    if (rst)       idx <= '0;
    else if (wrap) idx <= '0;
    else if (tick) idx <= idx + 1'b1;
  end

  // Double buffer: swap uses the pre-load shadow; a load on the wrap
  // cycle therefore stays pending for one more frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (wrap && pending) active <= shadow;
      if (load_i) begin
        shadow  <= value_i;
        pending <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_zero
    assign zero_from[k] = (active[DIGITS-1:k] == '0);
  end

  assign num_o      = active[idx];
  assign digit_en_o = DIGITS'(1) << idx;
  assign pending_o  = pending;
  assign blank_o    = blank_lz_i && (idx != '0) && zero_from[idx];

endmodule

// File: tb/tb_digit_scanner.sv
// Randomized + directed bench for digit_scanner against a cycle-count model.
module tb_digit_scanner;

  localparam int D     = 4;
  localparam int V     = 4;
  localparam int FRAME = D * V;

  logic            clk = 1'b0;
  logic            rst;
  logic [4*D-1:0]  value_i;
  logic            load_i;
  logic            blank_lz_i;
  logic [3:0]      num_o;
  logic [D-1:0]    digit_en_o;
  logic            blank_o;
  logic            pending_o;

  int checks   = 0;
  int failures = 0;

  // reference state: cycles since reset plus buffer contents
  int              m_cyc;
  logic [4*D-1:0]  m_shadow;
  logic [4*D-1:0]  m_active;
  bit              m_pending;

  always #5 clk = ~clk;

  digit_scanner #(.DIGITS(D), .DIV(V)) dut (
    .clk        (clk),
    .rst        (rst),
    .value_i    (value_i),
    .load_i     (load_i),
    .blank_lz_i (blank_lz_i),
    .num_o      (num_o),
    .digit_en_o (digit_en_o),
    .blank_o    (blank_o),
    .pending_o  (pending_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, m_cyc);
    end
  endtask

  function automatic int m_idx();
    return (m_cyc / V) % D;
  endfunction

  function automatic bit m_wrap();
    return (m_cyc % FRAME) == FRAME - 1;
  endfunction

  // Advance the model by one rising edge using the current inputs.
  task automatic model_edge();
    bit wr;
    if (rst) begin
      m_cyc = 0; m_shadow = '0; m_active = '0; m_pending = 0;
    end else begin
      wr = m_wrap();
      if (wr && m_pending) m_active = m_shadow;
      if (load_i) begin
        m_shadow = value_i; m_pending = 1;
      end else if (wr) begin
        m_pending = 0;
      end
      m_cyc++;
    end
  endtask

  task automatic check_outputs();
    int i;
    logic [4*D-1:0] upper;
    i = m_idx();
    upper = m_active >> (4 * i);
    chk("num",     32'(num_o),      32'(upper[3:0]));
    chk("digit_en",32'(digit_en_o), 32'(1 << i));
    chk("blank",   32'(blank_o),    32'(blank_lz_i && i != 0 && upper == '0));
    chk("pending", 32'(pending_o),  32'(m_pending));
  endtask

  // Check current outputs, then clock once and update the model.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b1; load_i = 1'b0; value_i = '0; blank_lz_i = 1'b0;
    m_cyc = 0; m_shadow = '0; m_active = '0; m_pending = 0;
    @(posedge clk);
    model_edge();
    #1;
    rst = 1'b0;
    #1;
    chk("rst_en",   32'(digit_en_o), 32'h1);
    chk("rst_num",  32'(num_o),      32'h0);
    chk("rst_pend", 32'(pending_o),  32'h0);
    chk("rst_blank",32'(blank_o),    32'h0);

    // free run, no load
    run(2 * FRAME + 4);

    // mid-frame load of 1234
    for (int i = 0; i < 64 && (m_cyc % FRAME) != 5; i++) cycle();
    value_i = 16'h1234; load_i = 1'b1;
    cycle();
    load_i = 1'b0;
    #1 chk("pend_after_load", 32'(pending_o), 32'h1);

    // load ABCD exactly on the wrap cycle while 1234 is pending
    for (int i = 0; i < 64 && !m_wrap(); i++) cycle();
    value_i = 16'hABCD; load_i = 1'b1;
    cycle();
    load_i = 1'b0;
    #1 chk("num_1234_d0", 32'(num_o), 32'h4);
    chk("pend_after_wrap_load", 32'(pending_o), 32'h1);
    run(FRAME);
    #1 chk("num_abcd_d0", 32'(num_o), 32'hD);
    run(FRAME);

    // leading-zero blanking with 0070, then all zero
    blank_lz_i = 1'b1;
    value_i = 16'h0070; load_i = 1'b1;
    cycle();
    load_i = 1'b0;
    run(3 * FRAME);
    value_i = 16'h0000; load_i = 1'b1;
    cycle();
    load_i = 1'b0;
    run(3 * FRAME);
    blank_lz_i = 1'b0;

    // reset during digit 2 with a load pending
    value_i = 16'h5555; load_i = 1'b1;
    cycle();
    load_i = 1'b0;
    for (int i = 0; i < 64 && m_idx() != 2; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1 chk("rst2_en", 32'(digit_en_o), 32'h1);
    chk("rst2_pend", 32'(pending_o), 32'h0);
    chk("rst2_num",  32'(num_o),     32'h0);
    run(FRAME + 4);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      load_i     = ($urandom_range(0, 9) == 0);
      value_i    = 16'($urandom);
      if ($urandom_range(0, 3) == 0) value_i = value_i & 16'h00FF;
      if ($urandom_range(0, 7) == 0) value_i = '0;
      blank_lz_i = $urandom_range(0, 1) == 1;
      rst        = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0; load_i = 1'b0;
    run(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
